// File: rtl/stream_frame_pkg.sv
// Shared types and default sizing for the stream frame reader.
package stream_frame_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_FRAME_WORDS = 5184;
    localparam int DEF_CNT_W       = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: registered output, one-cycle latency, full throughput.
module stream_skid_buf #(
    parameter int DATA_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p0;
    logic              vld_p1;
    logic              push;
    logic              pop;

    // Not-full: the second slot absorbs one word while the head is stalled.
    assign in_ready  = !vld_p1;
    assign push      = in_valid && in_ready;
    assign pop       = vld_p0 && out_ready;
    assign out_data  = data_p0;
    assign out_valid = vld_p0;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p0 <= '0;
            data_p1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!vld_p0) begin
                        data_p0 <= in_data;
                        vld_p0  <= 1'b1;
                    end else begin
                        data_p1 <= in_data;
                        vld_p1  <= 1'b1;
                    end
                end
                2'b01: begin
                    data_p0 <= data_p1;
                    vld_p0  <= vld_p1;
                    vld_p1  <= 1'b0;
                end
                // Push and pop together only happens with a single entry held.
                2'b11: data_p0 <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stream_frame_reader.sv
// Frames a FIFO read stream into FRAME_WORDS-word packets with TLAST.
// Optional macro STREAM_FRAME_READER_STALL_STATS_EN adds the stall_cycles counter port.
module stream_frame_reader
    import stream_frame_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic [WIDTH-1:0] in0_V_TDATA,
    input  logic             in0_V_TVALID,
    output logic             in0_V_TREADY,
    output logic [WIDTH-1:0] out_V_TDATA,
    output logic             out_V_TVALID,
    input  logic             out_V_TREADY,
    output logic             out_V_TLAST,
    output logic [CNT_W-1:0] word_idx,
    output logic [31:0]      frame_count,
    output logic             busy
`ifdef STREAM_FRAME_READER_STALL_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

    state_t         state;
    state_t         state_nxt;
    logic           skid_in_ready;
    logic           push;
    logic           is_last;
    logic           out_hs;
    logic           frame_done;
    logic [WIDTH:0] skid_in;
    logic [WIDTH:0] skid_out;

    assign is_last    = (word_idx == LAST_IDX);
    assign push       = (state == STREAM) && in0_V_TVALID && skid_in_ready;
    assign out_hs     = out_V_TVALID && out_V_TREADY;
    assign frame_done = (state == DRAIN) && out_hs && out_V_TLAST;
    assign skid_in    = {is_last, in0_V_TDATA};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in0_V_TREADY = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0 || in0_V_TVALID) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy         = 1'b1;
                in0_V_TREADY = skid_in_ready;
                if (push && is_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Input stays closed until the tagged word has left the buffer.
                busy = 1'b1;
                if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_idx    <= '0;
            frame_count <= '0;
        end else begin
            if (push) begin
                word_idx <= is_last ? '0 : word_idx + 1'b1;
            end
            if (frame_done) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

    stream_skid_buf #(
        .DATA_W (WIDTH + 1)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_data   (skid_in),
        .in_valid  (push),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (out_V_TVALID),
        .out_ready (out_V_TREADY)
    );

    assign out_V_TDATA = skid_out[WIDTH-1:0];
    assign out_V_TLAST = skid_out[WIDTH];

`ifdef STREAM_FRAME_READER_STALL_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (out_V_TVALID && !out_V_TREADY) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end
`endif

endmodule

// File: doc/stream_frame_reader.md
STREAM_FRAME_READER -- requirements
Module: stream_frame_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning stream data width in bits.
REQ-002 SHALL have parameter FRAME_WORDS, default 5184, meaning words per frame (range 2..8191).
REQ-003 SHALL have parameter CNT_W, default 13, meaning width of the occupancy and word-index fields.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port fifo_count, input, CNT_W bits: occupancy reported by the upstream FIFO.
REQ-007 SHALL have ports in0_V_TDATA (input, WIDTH), in0_V_TVALID (input, 1) and in0_V_TREADY (output, 1): the FIFO-side read stream.
REQ-008 SHALL have ports out_V_TDATA (output, WIDTH), out_V_TVALID (output, 1), out_V_TREADY (input, 1) and out_V_TLAST (output, 1): the framed output stream.
REQ-009 SHALL have port word_idx, output, CNT_W bits: index of the next word to be accepted within the current frame.
REQ-010 SHALL have port frame_count, output, 32 bits: number of completed frames.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-013 IDLE: in0_V_TREADY SHALL be low; go to STREAM when fifo_count >= 1 or in0_V_TVALID is high.
REQ-014 STREAM: in0_V_TREADY SHALL equal skid-buffer not-full; each handshake (TVALID && TREADY) SHALL increment word_idx.
REQ-015 STREAM: the accepted word at word_idx == FRAME_WORDS-1 SHALL be tagged last; word_idx SHALL then wrap to 0 and the FSM SHALL go to DRAIN.
REQ-016 DRAIN: in0_V_TREADY SHALL be low until the tagged last word completes its output handshake, then the FSM SHALL go to IDLE and frame_count SHALL increment by 1, wrapping modulo 2^32.
REQ-017 Output SHALL pass through a 2-entry skid buffer: latency input-handshake to out_V_TVALID is exactly 1 cycle, with full throughput of 1 word/cycle when out_V_TREADY is held high.
REQ-018 out_V_TDATA and out_V_TLAST SHALL hold stable while out_V_TVALID is high and out_V_TREADY is low.
REQ-019 Simultaneous push and pop on a full skid buffer SHALL be disallowed by deasserting in0_V_TREADY; no word is dropped or duplicated.
REQ-020 busy SHALL be high in STREAM and DRAIN and low in IDLE.
REQ-021 word_idx SHALL never equal or exceed FRAME_WORDS.

Reset
REQ-022 On reset, the FSM SHALL go to IDLE.
REQ-023 On reset, word_idx SHALL be 0, frame_count SHALL be 0, busy SHALL be 0, out_V_TVALID SHALL be 0, out_V_TLAST SHALL be 0, out_V_TDATA SHALL be 0 and in0_V_TREADY SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL discard buffered words and the partial count; the next frame SHALL start at word_idx 0.

Configuration
REQ-025 When STREAM_FRAME_READER_STALL_STATS_EN is defined, an output port stall_cycles (32 bits) SHALL exist, counting cycles with out_V_TVALID high and out_V_TREADY low; it SHALL saturate at 2^32-1 and clear on reset.
REQ-026 When STREAM_FRAME_READER_STALL_STATS_EN is undefined, the stall_cycles port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package stream_frame_pkg SHALL hold the FSM state enum, and the default WIDTH, FRAME_WORDS and CNT_W constants.
REQ-028 The skid buffer SHALL be a separate sub-module, stream_skid_buf, parameterised by WIDTH+1 bits (data plus last).

Verification
REQ-029 FRAME_WORDS=4, out_V_TREADY held 1, 8 words 0x0001..0x0008 -> outputs in order, TLAST on 0x0004 and 0x0008, frame_count=2.
REQ-030 out_V_TREADY low for 5 cycles mid-frame -> out_V_TDATA stable throughout, in0_V_TREADY low after 2 buffered words, no loss.
REQ-031 Random TVALID/TREADY over 1000 frames of FRAME_WORDS=5184 -> scoreboard match, frame_count=1000.
REQ-032 Reset asserted at word_idx=3 -> all outputs at reset values next cycle; next frame TLAST after exactly FRAME_WORDS words.
REQ-033 With STREAM_FRAME_READER_STALL_STATS_EN defined, 7 stalled cycles -> stall_cycles=7.
